// File: rtl/inst_bus_responder.sv
// Instruction-bus read responder: accepts a fetch, reads one word from a fixed-latency
// synchronous RAM, extracts word/halfword/byte and returns it with a one-cycle valid pulse.
module inst_bus_responder #(
    parameter int          MEM_WORDS = 4096,
    parameter int          AW        = 12,
    parameter int          RD_LAT    = 1,
    parameter logic [31:0] NOP_INST  = 32'h00000013
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_read_req,
    input  logic          i_read_w,
    input  logic          i_read_hw,
    input  logic [31:0]   i_read_adr,
    output logic          i_read_valid,
    output logic [31:0]   i_read_data,
    input  logic          flush,
    output logic          mem_req,
    output logic [AW-1:0] mem_adr,
    input  logic [31:0]   mem_rdata,
    output logic          busy,
    output logic          err_range,
    output logic          err_overrun
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    // Wide enough for the largest legal read latency (4).
    localparam int CW = 3;

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] lat_cnt;
    logic          acc_w;
    logic          acc_hw;
    logic [1:0]    acc_lo;

    logic          in_range;
    logic          accept_mem;
    logic          accept_oor;
    logic          capture;
    logic          overrun;

    function automatic logic [31:0] format_read(
        input logic [31:0] word,
        input logic        is_w,
        input logic        is_hw,
        input logic [1:0]  lo
    );
        logic [31:0] r;
        r = word;
        if (!is_w) begin
            if (is_hw) begin
                r = {16'h0000, (lo[1] ? word[31:16] : word[15:0])};
            end else begin
                case (lo)
                    2'd0:    r = {24'h000000, word[7:0]};
                    2'd1:    r = {24'h000000, word[15:8]};
                    2'd2:    r = {24'h000000, word[23:16]};
                    default: r = {24'h000000, word[31:24]};
                endcase
            end
        end
        return r;
    endfunction

    assign in_range = ({2'b00, i_read_adr[31:2]} < 32'(MEM_WORDS));

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_next   = state;
        accept_mem   = 1'b0;
        accept_oor   = 1'b0;
        capture      = 1'b0;
        mem_req      = 1'b0;
        i_read_valid = 1'b0;
        busy         = (state != IDLE);
        overrun      = i_read_req && (state != IDLE);

        case (state)
            IDLE: begin
                // A flush in the same cycle as a request drops the request entirely.
                if (i_read_req && !flush) begin
                    if (in_range) begin
                        accept_mem = 1'b1;
                        state_next = ISSUE;
                    end else begin
                        accept_oor = 1'b1;
                        state_next = RESP;
                    end
                end
            end
            ISSUE: begin
                mem_req    = 1'b1;
                state_next = flush ? IDLE : WAIT;
            end
            WAIT: begin
                if (flush) begin
                    state_next = IDLE;
                end else if (lat_cnt == CW'(1)) begin
                    capture    = 1'b1;
                    state_next = RESP;
                end
            end
            RESP: begin
                i_read_valid = 1'b1;
                state_next   = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lat_cnt     <= '0;
            acc_w       <= 1'b0;
            acc_hw      <= 1'b0;
            acc_lo      <= 2'b00;
            mem_adr     <= '0;
            i_read_data <= 32'h0;
            err_range   <= 1'b0;
            err_overrun <= 1'b0;
        end else begin
            if (accept_mem) begin
                acc_w   <= i_read_w;
                acc_hw  <= i_read_hw;
                acc_lo  <= i_read_adr[1:0];
                mem_adr <= i_read_adr[AW+1:2];
            end

            if (accept_oor) begin
                i_read_data <= NOP_INST;
                err_range   <= 1'b1;
            end else if (capture) begin
                i_read_data <= format_read(mem_rdata, acc_w, acc_hw, acc_lo);
            end

            if (overrun) begin
                err_overrun <= 1'b1;
            end

            // Counter is only meaningful in WAIT; cleared elsewhere so an abort leaves no residue.
            case (state)
                ISSUE:   lat_cnt <= flush ? '0 : CW'(RD_LAT);
                WAIT:    lat_cnt <= flush ? '0 : lat_cnt - CW'(1);
                default: lat_cnt <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_inst_bus_responder.sv
// Bench for inst_bus_responder: two instances (read latency 1 and 3) share one stimulus stream
// and are compared every cycle against a transaction-level reference model.
module tb_inst_bus_responder;

    localparam int          MEM_WORDS = 4096;
    localparam int          AW        = 12;
    localparam int          LAT0      = 1;
    localparam int          LAT1      = 3;
    localparam logic [31:0] NOP       = 32'h00000013;

    typedef struct {
        logic [31:0] adr;
        bit          w;
        bit          hw;
        logic [31:0] exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic        w;
    logic        hw;
    logic        flush;
    logic [31:0] adr;
    logic [31:0] ram [MEM_WORDS];
    int          cyc = 0;

    logic          v_o  [2];
    logic [31:0]   d_o  [2];
    logic          mr_o [2];
    logic [AW-1:0] ma_o [2];
    logic          b_o  [2];
    logic          er_o [2];
    logic          eo_o [2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int L = (g == 0) ? LAT0 : LAT1;
        logic          v, mr, b, er, eo;
        logic [31:0]   d, rd;
        logic [AW-1:0] ma;
        logic [31:0]   pipe [L];

        inst_bus_responder #(
            .MEM_WORDS(MEM_WORDS),
            .AW       (AW),
            .RD_LAT   (L),
            .NOP_INST (NOP)
        ) dut (
            .clk         (clk),
            .rst         (rst),
            .i_read_req  (req),
            .i_read_w    (w),
            .i_read_hw   (hw),
            .i_read_adr  (adr),
            .i_read_valid(v),
            .i_read_data (d),
            .flush       (flush),
            .mem_req     (mr),
            .mem_adr     (ma),
            .mem_rdata   (rd),
            .busy        (b),
            .err_range   (er),
            .err_overrun (eo)
        );

        // RAM model: data appears L cycles after mem_req; junk otherwise so mistimed capture shows.
        always @(posedge clk) begin
            pipe[0] <= mr ? ram[ma] : (32'hBAD0_0000 ^ 32'(cyc));
            for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
        end
        assign rd = pipe[L-1];

        assign v_o[g]  = v;
        assign d_o[g]  = d;
        assign mr_o[g] = mr;
        assign ma_o[g] = ma;
        assign b_o[g]  = b;
        assign er_o[g] = er;
        assign eo_o[g] = eo;
    end

    int          n_cmp = 0;
    int          n_bad = 0;
    bit          chk_en = 1'b0;

    // Reference model: one outstanding transaction per instance, described by its accept cycle
    // and the cycle in which its response is due.
    bit            m_act  [2];
    int            m_c0   [2];
    int            m_resp [2];
    bit            m_inr  [2];
    logic [31:0]   m_pend [2];
    logic [31:0]   m_data [2];
    logic [AW-1:0] m_madr [2];
    bit            m_er   [2];
    bit            m_eo   [2];
    bit            m_rstd [2];

    int            n_valid       [2];
    int            last_vcyc     [2];
    logic [31:0]   last_vdata    [2];
    int            last_mreq_cyc [2];
    int            step_cyc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] ref_fmt(input logic [31:0] word, input bit ww, input bit hh,
                                            input logic [1:0] lo);
        if (ww) return word;
        if (hh) return (word >> (16 * int'(lo[1]))) & 32'h0000_FFFF;
        return (word >> (8 * int'(lo))) & 32'h0000_00FF;
    endfunction

    task automatic check_outputs();
        for (int d = 0; d < 2; d++) begin
            bit ev;
            bit emr;
            ev  = m_act[d] && (cyc == m_resp[d]);
            emr = m_act[d] && m_inr[d] && (cyc == m_c0[d] + 1);
            if (v_o[d] === 1'b1) begin
                n_valid[d]++;
                last_vcyc[d]  = cyc;
                last_vdata[d] = d_o[d];
            end
            if (mr_o[d] === 1'b1) last_mreq_cyc[d] = cyc;
            if (chk_en) begin
                check($sformatf("dut%0d i_read_valid", d), 32'(v_o[d]), 32'(ev));
                check($sformatf("dut%0d i_read_data", d), d_o[d], m_data[d]);
                check($sformatf("dut%0d busy", d), 32'(b_o[d]), 32'(m_act[d]));
                check($sformatf("dut%0d mem_req", d), 32'(mr_o[d]), 32'(emr));
                check($sformatf("dut%0d err_range", d), 32'(er_o[d]), 32'(m_er[d]));
                check($sformatf("dut%0d err_overrun", d), 32'(eo_o[d]), 32'(m_eo[d]));
                if (emr || m_rstd[d])
                    check($sformatf("dut%0d mem_adr", d), 32'(ma_o[d]), 32'(m_madr[d]));
            end
        end
    endtask

    // Applies the rules for the edge that ends the current cycle, using the inputs now driven.
    task automatic model_update();
        int c;
        c = cyc;
        for (int d = 0; d < 2; d++) begin
            int lat;
            lat = (d == 0) ? LAT0 : LAT1;
            m_rstd[d] = 1'b0;
            if (rst) begin
                m_act[d]  = 1'b0;
                m_data[d] = 32'h0;
                m_madr[d] = '0;
                m_er[d]   = 1'b0;
                m_eo[d]   = 1'b0;
                m_rstd[d] = 1'b1;
            end else if (m_act[d]) begin
                if (req) m_eo[d] = 1'b1;
                if (c == m_resp[d] || flush) m_act[d] = 1'b0;
            end else if (req && !flush) begin
                m_act[d] = 1'b1;
                m_c0[d]  = c;
                if ({2'b00, adr[31:2]} < 32'(MEM_WORDS)) begin
                    m_inr[d]  = 1'b1;
                    m_resp[d] = c + 2 + lat;
                    m_madr[d] = adr[AW+1:2];
                    m_pend[d] = ref_fmt(ram[adr[AW+1:2]], w, hw, adr[1:0]);
                end else begin
                    m_inr[d]  = 1'b0;
                    m_resp[d] = c + 1;
                    m_pend[d] = NOP;
                    m_er[d]   = 1'b1;
                end
            end
            if (m_act[d] && m_resp[d] == c + 1) m_data[d] = m_pend[d];
        end
        if (rst) chk_en = 1'b1;
    endtask

    task automatic step(input bit r, input bit q, input bit ww, input bit hh,
                        input logic [31:0] a, input bit f);
        @(negedge clk);
        check_outputs();
        rst   = r;
        req   = q;
        w     = ww;
        hw    = hh;
        adr   = a;
        flush = f;
        step_cyc = cyc;
        model_update();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    endtask

    vec_t vecs [13];
    int   nv0, nv1, t;
    bit   r_b, q_b, f_b, w_b, h_b;
    int   k;
    logic [31:0] a_r;

    initial begin
        vecs[0]  = '{32'h0000_0010, 1'b1, 1'b0, 32'hDEAD_BEEF};
        vecs[1]  = '{32'h0000_0012, 1'b0, 1'b1, 32'h0000_DEAD};
        vecs[2]  = '{32'h0000_0010, 1'b0, 1'b1, 32'h0000_BEEF};
        vecs[3]  = '{32'h0000_0013, 1'b0, 1'b0, 32'h0000_00DE};
        vecs[4]  = '{32'h0000_0010, 1'b0, 1'b0, 32'h0000_00EF};
        vecs[5]  = '{32'h0000_0011, 1'b0, 1'b0, 32'h0000_00BE};
        vecs[6]  = '{32'h0000_0012, 1'b0, 1'b0, 32'h0000_00AD};
        vecs[7]  = '{32'h0000_0013, 1'b1, 1'b0, 32'hDEAD_BEEF};
        vecs[8]  = '{32'h0000_3FFC, 1'b1, 1'b0, 32'h0123_4567};
        vecs[9]  = '{32'h0000_3FFE, 1'b0, 1'b1, 32'h0000_0123};
        vecs[10] = '{32'h0000_4000, 1'b1, 1'b0, 32'h0000_0013};
        vecs[11] = '{32'h0000_4002, 1'b0, 1'b1, 32'h0000_0013};
        vecs[12] = '{32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0000_0013};

        for (int i = 0; i < MEM_WORDS; i++) ram[i] = $urandom;
        ram[4]           = 32'hDEAD_BEEF;
        ram[5]           = 32'hCAFE_F00D;
        ram[MEM_WORDS-1] = 32'h0123_4567;
        for (int d = 0; d < 2; d++) begin
            n_valid[d] = 0; last_vcyc[d] = -1; last_mreq_cyc[d] = -1; last_vdata[d] = 32'h0;
            m_act[d] = 1'b0; m_rstd[d] = 1'b0;
        end

        rst = 1'b1; req = 1'b0; w = 1'b0; hw = 1'b0; adr = 32'h0; flush = 1'b0;
        model_update();
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        idle(2);

        // Word fetch latency with RD_LAT=1.
        nv0 = n_valid[0];
        step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0010, 1'b0);
        t = step_cyc;
        idle(6);
        check("word valid count", 32'(n_valid[0] - nv0), 32'd1);
        check("word mem_req cycle", 32'(last_mreq_cyc[0] - t), 32'd1);
        check("word valid cycle", 32'(last_vcyc[0] - t), 32'd3);
        check("word valid cycle lat3", 32'(last_vcyc[1] - t), 32'd5);
        check("word data", last_vdata[0], 32'hDEAD_BEEF);

        // Formatting and out-of-range table.
        for (int i = 0; i < 13; i++) begin
            nv0 = n_valid[0];
            nv1 = n_valid[1];
            step(1'b0, 1'b1, vecs[i].w, vecs[i].hw, vecs[i].adr, 1'b0);
            idle(7);
            check($sformatf("vec%0d count lat1", i), 32'(n_valid[0] - nv0), 32'd1);
            check($sformatf("vec%0d count lat3", i), 32'(n_valid[1] - nv1), 32'd1);
            check($sformatf("vec%0d data lat1", i), last_vdata[0], vecs[i].exp);
            check($sformatf("vec%0d data lat3", i), last_vdata[1], vecs[i].exp);
        end
        check("err_range after oor", 32'(er_o[0]), 32'd1);

        // Second request during WAIT is ignored and flagged.
        check("err_overrun before", 32'(eo_o[0]), 32'd0);
        nv0 = n_valid[0];
        nv1 = n_valid[1];
        step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0010, 1'b0);
        idle(1);
        step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0014, 1'b0);
        idle(7);
        check("overrun count lat1", 32'(n_valid[0] - nv0), 32'd1);
        check("overrun count lat3", 32'(n_valid[1] - nv1), 32'd1);
        check("overrun data lat3", last_vdata[1], 32'hDEAD_BEEF);
        check("err_overrun set", 32'(eo_o[1]), 32'd1);

        // Flush in WAIT (lat3) lands on RESP for lat1, which must still respond.
        nv0 = n_valid[0];
        nv1 = n_valid[1];
        step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0010, 1'b0);
        idle(2);
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        idle(1);
        check("flush busy low next", 32'(b_o[1]), 32'd0);
        idle(6);
        check("flush no valid lat3", 32'(n_valid[1] - nv1), 32'd0);
        check("flush in RESP keeps valid", 32'(n_valid[0] - nv0), 32'd1);
        step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0020, 1'b1);
        idle(5);
        check("flush+req drops", 32'(n_valid[1] - nv1), 32'd0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0014, 1'b0);
        idle(7);
        check("after flush count", 32'(n_valid[1] - nv1), 32'd1);
        check("after flush data", last_vdata[1], 32'hCAFE_F00D);

        // Reset during WAIT drops the read and clears sticky errors.
        nv0 = n_valid[0];
        nv1 = n_valid[1];
        step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0010, 1'b0);
        idle(1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        idle(1);
        check("rst err_range", 32'(er_o[1]), 32'd0);
        check("rst err_overrun", 32'(eo_o[1]), 32'd0);
        check("rst data", d_o[1], 32'h0);
        idle(7);
        check("rst no valid lat1", 32'(n_valid[0] - nv0), 32'd0);
        check("rst no valid lat3", 32'(n_valid[1] - nv1), 32'd0);

        // Randomized traffic against the model.
        for (int i = 0; i < 800; i++) begin
            r_b = ($urandom_range(0, 199) == 0);
            q_b = ($urandom_range(0, 99) < 35);
            f_b = ($urandom_range(0, 99) < 6);
            w_b = ($urandom_range(0, 2) == 0);
            h_b = ($urandom_range(0, 1) == 1);
            k   = $urandom_range(0, 9);
            if (k == 0)      a_r = $urandom;
            else if (k == 1) a_r = 32'(MEM_WORDS * 4) + 32'($urandom_range(0, 3));
            else if (k == 2) a_r = 32'(MEM_WORDS * 4 - 4) + 32'($urandom_range(0, 3));
            else             a_r = 32'($urandom_range(0, MEM_WORDS * 4 - 1));
            step(r_b, q_b, w_b, h_b, a_r, f_b);
        end
        idle(8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/inst_bus_responder.md
Name: inst_bus_responder

Overview:
Instruction-bus slave directly downstream of the instruction fetch/read stage. It accepts single-cycle read requests on the i_read_* bus, issues a word read to a synchronous instruction RAM with fixed read latency, extracts the word, halfword or byte, and returns it with a one-cycle i_read_valid pulse. Out-of-range fetches return NOP and set a sticky error. A flush input aborts an in-flight read.

Parameters:
MEM_WORDS, 4096, instruction RAM depth in 32-bit words.
AW, 12, RAM word-address width; must satisfy 2^AW >= MEM_WORDS.
RD_LAT, 1, RAM read latency in cycles (mem_req cycle to mem_rdata valid); legal range 1..4.
NOP_INST, 32'h00000013, word returned for out-of-range fetches.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous reset, active-high
i_read_req  in  1  one-cycle read request pulse
i_read_w  in  1  word access
i_read_hw  in  1  halfword access; byte access when i_read_w=0 and i_read_hw=0
i_read_adr  in  32  byte address
i_read_valid  out  1  one-cycle response-valid pulse
i_read_data  out  32  response data, zero-extended for halfword and byte accesses
flush  in  1  abort the in-flight request
mem_req  out  1  RAM read strobe
mem_adr  out  AW  RAM word address
mem_rdata  in  32  RAM read data, valid RD_LAT cycles after mem_req
busy  out  1  high whenever the state is not IDLE
err_range  out  1  sticky: an out-of-range fetch has occurred
err_overrun  out  1  sticky: a request arrived while busy

Behaviour:
- Reset (rst=1 at a rising edge): state=IDLE; i_read_valid=0, i_read_data=0, mem_req=0, mem_adr=0, err_range=0, err_overrun=0, latency counter=0. Reset mid-read drops the read; no valid follows.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE, i_read_req=1: latch the address, width and adr[1:0].
  - In range (i_read_adr[31:2] < MEM_WORDS): go to ISSUE.
  - Out of range: go to RESP with data=NOP_INST (width ignored) and set err_range.
- ISSUE: mem_req=1 for exactly one cycle, mem_adr=latched adr[AW+1:2]. Load counter=RD_LAT and go to WAIT.
- WAIT: decrement the counter each cycle. When mem_rdata is valid (counter reaches 0), capture and format it, then go to RESP.
- RESP: i_read_valid=1 for exactly one cycle with i_read_data stable. Go to IDLE.
- Latency: request sampled at edge T, mem_req high during cycle T+1, i_read_valid high during cycle T+2+RD_LAT. Out-of-range path: i_read_valid during cycle T+1.
- i_read_data holds its last value between responses.
- Formatting:
  - Word: full word; adr[1:0] ignored.
  - Halfword: adr[1]=0 gives bits [15:0], adr[1]=1 gives bits [31:16].
  - Byte: adr[1:0] selects byte 0..3.
  - Upper bits are zero.
- Requests while not IDLE are ignored (no queue) and set err_overrun. A request in the same cycle as RESP is also an overrun; IDLE is re-entered only on the following cycle.
- flush=1 in ISSUE or WAIT: go to IDLE next cycle, no i_read_valid, and the late mem_rdata is ignored. flush in RESP does not suppress the valid. flush in IDLE has no effect. flush together with i_read_req in IDLE: the request is dropped.
- Sticky errors clear only on rst.

Test Plan:
- Word fetch, RD_LAT=1, adr=0x00000010, RAM[4]=0xDEADBEEF: mem_req in cycle 1 with mem_adr=4; i_read_valid in cycle 3 with 0xDEADBEEF; busy high for cycles 1-3.
- Halfword adr=0x12 and byte adr=0x13, RAM[4]=0xDEADBEEF: returns 0x0000DEAD and 0x000000DE.
- Out-of-range adr=0x00004000 (MEM_WORDS=4096): no mem_req; valid the next cycle with 0x00000013; err_range=1.
- Back-to-back: second i_read_req during WAIT is ignored and sets err_overrun; exactly one valid, for the first address.
- flush in WAIT with RD_LAT=3: no i_read_valid; busy low the next cycle; a new request then completes normally.
- rst asserted during WAIT: all outputs 0 the next cycle; no valid follows; sticky errors are cleared.
